// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: grants up to WB_WIDTH of REQ_NUM execution-unit
// result ports per cycle, in circular order from rr_ptr, and packs the winners
// into a registered writeback bundle. It also handles downstream stall and
// pipeline flush.

package wb_arbiter_pkg;
    typedef struct packed {
        logic        has_exception;
        logic        rd_enable;
        logic [5:0]  rd_phy;
        logic [31:0] rd_value;
        logic [4:0]  rob_id;
    } execute_wb_pack_t;
endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int REQ_NUM   = 6,
    parameter int WB_WIDTH  = 2,
    parameter int PTR_WIDTH = $clog2(REQ_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic             [REQ_NUM-1:0]       req_valid,
    input  execute_wb_pack_t [REQ_NUM-1:0]       req_data,
    output logic             [REQ_NUM-1:0]       req_ready,
    input  logic                                 wb_stall,
    input  logic                                 flush,
    output logic             [WB_WIDTH-1:0]      wb_out_valid,
    output execute_wb_pack_t [WB_WIDTH-1:0]      wb_out_data,
    output logic             [PTR_WIDTH-1:0]     rr_ptr
);

    logic             [WB_WIDTH-1:0]  wb_valid_q, wb_valid_d;
    execute_wb_pack_t [WB_WIDTH-1:0]  wb_data_q,  wb_data_d;
    logic             [PTR_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;

    logic             [REQ_NUM-1:0]   grant;
    logic             [WB_WIDTH-1:0]  scan_valid;
    execute_wb_pack_t [WB_WIDTH-1:0]  scan_data;
    logic             [PTR_WIDTH-1:0] ptr_next;
    logic                             any_grant;
    logic                             arb_en;

    // Grant selection: each requester's rank is the number of valid requesters
    // ahead of it in circular order from rr_ptr. Every index stays a loop
    // constant, so req_data is only ever routed by grant, never used to select.
    always_comb begin
        int pos  [REQ_NUM];
        int rank [REQ_NUM];
        int best_pos;

        grant      = '0;
        scan_valid = '0;
        scan_data  = '0;
        ptr_next   = rr_ptr_q;
        any_grant  = 1'b0;
        best_pos   = -1;

        for (int i = 0; i < REQ_NUM; i++) begin
            if (i >= int'(rr_ptr_q)) pos[i] = i - int'(rr_ptr_q);
            else                     pos[i] = i + REQ_NUM - int'(rr_ptr_q);
        end

        for (int i = 0; i < REQ_NUM; i++) begin
            rank[i] = 0;
            for (int k = 0; k < REQ_NUM; k++) begin
                if (req_valid[k] && (pos[k] < pos[i])) rank[i] = rank[i] + 1;
            end
        end

        for (int i = 0; i < REQ_NUM; i++) begin
            if (req_valid[i] && (rank[i] < WB_WIDTH)) begin
                grant[i]  = 1'b1;
                any_grant = 1'b1;
                if (pos[i] > best_pos) begin
                    best_pos = pos[i];
                    ptr_next = PTR_WIDTH'((i + 1) % REQ_NUM);
                end
            end
        end

        for (int c = 0; c < WB_WIDTH; c++) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (grant[i] && (rank[i] == c)) begin
                    scan_valid[c] = 1'b1;
                    scan_data[c]  = req_data[i];
                end
            end
        end
    end

    // Next-state selection: flush wins over stall, stall holds everything, and a
    // normal cycle loads a fresh bundle, which may be empty.
    always_comb begin
        arb_en     = rst && !flush && !wb_stall;
        req_ready  = '0;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        rr_ptr_d   = rr_ptr_q;

        if (arb_en) begin
            req_ready  = grant;
            wb_valid_d = scan_valid;
            wb_data_d  = scan_data;
            if (any_grant) rr_ptr_d = ptr_next;
        end else if (flush) begin
            wb_valid_d = '0;
            wb_data_d  = '0;
            rr_ptr_d   = '0;
        end
    end

    // Output bundle and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= '0;
            wb_data_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign wb_out_valid = wb_valid_q;
    assign wb_out_data  = wb_data_q;
    assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed test-plan steps followed by randomized traffic,
// checked against a grant-order reference model.

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 6;
    localparam int W = 2;
    localparam int P = $clog2(N);

    logic                          clk = 1'b0;
    logic                          rst;
    logic             [N-1:0]      req_valid;
    execute_wb_pack_t [N-1:0]      req_data;
    logic             [N-1:0]      req_ready;
    logic                          wb_stall;
    logic                          flush;
    logic             [W-1:0]      wb_out_valid;
    execute_wb_pack_t [W-1:0]      wb_out_data;
    logic             [P-1:0]      rr_ptr;

    wb_arbiter #(.REQ_NUM(N), .WB_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_stall     (wb_stall),
        .flush        (flush),
        .wb_out_valid (wb_out_valid),
        .wb_out_data  (wb_out_data),
        .rr_ptr       (rr_ptr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic             [W-1:0] m_val;
    execute_wb_pack_t [W-1:0] m_data;
    int                       m_ptr;
    int                       order[$];
    logic             [N-1:0] exp_ready;

    // random-phase requester state
    logic             [N-1:0] pend;
    execute_wb_pack_t         pdata [N];
    int                       waitc [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant order from the rules: walk the circle from ptr, take the first W valid.
    task automatic compute_order();
        order.delete();
        exp_ready = '0;
        if (rst && !flush && !wb_stall) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (req_valid[idx] && order.size() < W) begin
                    order.push_back(idx);
                    exp_ready[idx] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_edge();
        if (flush) begin
            m_val = '0;
            m_data = '0;
            m_ptr = 0;
        end else if (!wb_stall) begin
            m_val = '0;
            m_data = '0;
            for (int c = 0; c < order.size(); c++) begin
                m_val[c]  = 1'b1;
                m_data[c] = req_data[order[c]];
            end
            if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % N;
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, " valid"}, 128'(wb_out_valid), 128'(m_val));
        chk({tag, " data"},  128'(wb_out_data),  128'(m_data));
        chk({tag, " ptr"},   128'(rr_ptr),       128'(m_ptr));
    endtask

    // One clock: check the combinational grant mid-cycle, advance through the
    // edge, then check registered outputs. er/ep >= 0 add literal expectations.
    task automatic do_cycle(input string tag, input int er, input int ep);
        #2;
        compute_order();
        chk({tag, " ready"}, 128'(req_ready), 128'(exp_ready));
        if (er >= 0) chk({tag, " ready_lit"}, 128'(req_ready), 128'(er));
        @(posedge clk);
        #1;
        model_edge();
        chk_outputs(tag);
        if (ep >= 0) chk({tag, " ptr_lit"}, 128'(rr_ptr), 128'(ep));
    endtask

    initial begin
        rst = 1'b0;
        wb_stall = 1'b0;
        flush = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_data[i] = '0;
            req_data[i].rd_enable = 1'b1;
            req_data[i].rd_phy    = 6'(i);
            req_data[i].rd_value  = 32'h15263317 + 32'(i);
            req_data[i].rob_id    = 5'(i + 3);
        end
        m_val = '0;
        m_data = '0;
        m_ptr = 0;

        // reset
        #1;
        chk("rst ready", 128'(req_ready), 128'(0));
        chk_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        chk("rst held valid", 128'(wb_out_valid), 128'(0));
        rst = 1'b1;

        // full rotation
        do_cycle("rot1", 'b000011, 2);
        chk("rot1 phy", 128'({wb_out_data[1].rd_phy, wb_out_data[0].rd_phy}), 128'({6'd1, 6'd0}));
        do_cycle("rot2", 'b001100, 4);
        chk("rot2 phy", 128'({wb_out_data[1].rd_phy, wb_out_data[0].rd_phy}), 128'({6'd3, 6'd2}));
        do_cycle("rot3", 'b110000, 0);
        chk("rot3 phy", 128'({wb_out_data[1].rd_phy, wb_out_data[0].rd_phy}), 128'({6'd5, 6'd4}));
        do_cycle("rot4", 'b000011, 2);
        chk("rot4 phy", 128'({wb_out_data[1].rd_phy, wb_out_data[0].rd_phy}), 128'({6'd1, 6'd0}));

        // stall
        wb_stall = 1'b1;
        do_cycle("stall1", 0, 2);
        do_cycle("stall2", 0, 2);
        chk("stall phy", 128'({wb_out_data[1].rd_phy, wb_out_data[0].rd_phy}), 128'({6'd1, 6'd0}));
        chk("stall valid", 128'(wb_out_valid), 128'(2'b11));
        wb_stall = 1'b0;
        do_cycle("unstall", 'b001100, 4);

        // flush together with stall
        flush = 1'b1;
        wb_stall = 1'b1;
        do_cycle("flush", 0, 0);
        chk("flush valid", 128'(wb_out_valid), 128'(2'b00));
        flush = 1'b0;
        wb_stall = 1'b0;

        // sparse
        req_valid = 6'b010000;
        do_cycle("sparse", 'b010000, 5);
        chk("sparse phy", 128'(wb_out_data[0].rd_phy), 128'(4));
        chk("sparse value", 128'(wb_out_data[0].rd_value), 128'(32'h1526331B));
        chk("sparse valid", 128'(wb_out_valid), 128'(2'b01));

        // wrap
        req_valid = 6'b100011;
        do_cycle("wrap", 'b100001, 1);
        chk("wrap phy", 128'({wb_out_data[1].rd_phy, wb_out_data[0].rd_phy}), 128'({6'd0, 6'd5}));

        // randomized traffic; requester 1 is still owed a grant
        pend = 6'b000010;
        for (int i = 0; i < N; i++) begin
            pdata[i] = req_data[i];
            waitc[i] = 0;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                rst = 1'b0;
                #1;
                m_val = '0;
                m_data = '0;
                m_ptr = 0;
                chk("midrst ready", 128'(req_ready), 128'(0));
                chk_outputs("midrst");
                pend = '0;
                for (int i = 0; i < N; i++) waitc[i] = 0;
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdata[i].has_exception = 1'($urandom);
                    pdata[i].rd_enable     = 1'($urandom);
                    pdata[i].rd_phy        = 6'($urandom);
                    pdata[i].rd_value      = $urandom;
                    pdata[i].rob_id        = 5'($urandom);
                end
            end
            wb_stall  = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            req_valid = pend;
            for (int i = 0; i < N; i++) req_data[i] = pdata[i];

            do_cycle("rand", -1, -1);

            if (flush) begin
                for (int i = 0; i < N; i++) begin
                    waitc[i] = 0;
                    if ($urandom_range(0, 1) == 0) pend[i] = 1'b0;
                end
            end else if (!wb_stall) begin
                for (int i = 0; i < N; i++) begin
                    if (exp_ready[i]) begin
                        chk("fairness", 128'(waitc[i] <= 2), 128'(1));
                        pend[i]  = 1'b0;
                        waitc[i] = 0;
                    end else if (pend[i]) begin
                        waitc[i]++;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin scheduler that shares the `WB_WIDTH` writeback channels among all execution-unit result ports. Each cycle it grants up to `WB_WIDTH` requesting units and packs their `execute_wb_pack_t` results into a registered writeback bundle. The writeback stage consumes this bundle to drive the physical register file write ports, the wakeup feedback and the commit port. Downstream stall and pipeline flush are handled here, so units may finish in any order without colliding on writeback channels.

## Interface
Parameters:
- `REQ_NUM`, default 6: number of requesting execution-unit ports (ALU+BRU+CSR+DIV+LSU+MUL), ≥ 2.
- `WB_WIDTH`, default 2: writeback channels per cycle, 1 ≤ `WB_WIDTH` ≤ `REQ_NUM`.
- `PTR_WIDTH`, default `$clog2(REQ_NUM)`: round-robin pointer width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = in reset).
- `req_valid`  in  `REQ_NUM`  unit i has a result pending.
- `req_data`  in  `REQ_NUM` x `execute_wb_pack_t`  result payload of unit i.
- `req_ready`  out  `REQ_NUM`  combinational; unit i is granted and its payload is captured at this edge.
- `wb_stall`  in  1  writeback cannot accept a new bundle this cycle.
- `flush`  in  1  pipeline flush from commit.
- `wb_out_valid`  out  `WB_WIDTH`  registered; channel k holds a valid result.
- `wb_out_data`  out  `WB_WIDTH` x `execute_wb_pack_t`  registered channel payloads.
- `rr_ptr`  out  `PTR_WIDTH`  registered; current highest-priority requester index (observability).

## Operation
- Scan order: circular, starting at `rr_ptr`: rr_ptr, rr_ptr+1, …, wrapping modulo `REQ_NUM`.
- Grant: in scan order, pick the first `WB_WIDTH` indices with `req_valid`=1. Set `req_ready` only for those indices.
- Packing: the n-th granted requester in scan order goes to channel n. Unfilled channels get `wb_out_valid`=0 and a zeroed payload.
- Payload contents (`has_exception`, `rd_enable`, …) do not affect arbitration.
- Pointer update on a normal cycle with ≥1 grant: `rr_ptr` ← (index of last grant + 1) mod `REQ_NUM`. With 0 grants, `rr_ptr` is unchanged.
- Stall (`wb_stall`=1, `flush`=0): `req_ready`=0. Output registers and `rr_ptr` hold.
- Flush (`flush`=1): has priority over stall. `req_ready`=0. At the edge, all `wb_out_valid` clear, payloads are zeroed and `rr_ptr` ← 0.
- Requester contract: hold `req_valid` and `req_data` stable until `req_ready`=1 is seen at an edge. Deasserting `req_valid` before a grant is allowed only on flush.
- Fairness: a continuously valid requester is granted within ceil(`REQ_NUM`/`WB_WIDTH`) non-stall, non-flush cycles.

## Timing
- Reset (`rst`=0, asynchronous): `wb_out_valid`=0, `wb_out_data`=0, `rr_ptr`=0 immediately. `req_ready` is forced to 0 while `rst`=0.
- Reset release: arbitration starts in the first cycle with `rst`=1. A deassertion mid-transfer discards any bundle in flight.
- Grant-to-output latency: 1 cycle. `req_ready` is high in cycle N, and the payload appears on `wb_out_*` in cycle N+1.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr`, `wb_stall`, `flush` and `rst` only, never on `req_data`.
- Back-to-back: a requester granted in cycle N may present a new result in cycle N+1 and be granted again if it is first in scan order.
- Wrap-around: the scan crosses index `REQ_NUM`-1 → 0 within one cycle.
- Pointer wrap: last grant at index `REQ_NUM`-1 sets `rr_ptr`=0.
- Simultaneous `flush` and `wb_stall`: flush behaviour applies.

## Test plan
(`REQ_NUM`=6, `WB_WIDTH`=2; `req_data[i].rd_phy`=i, `rd_value`='h15263317+i)
- Reset: `rst`=0 with all `req_valid`=1 → `req_ready`=0, `wb_out_valid`=00, `rr_ptr`=0. After release, the first cycle gives `req_ready`=000011.
- Full rotation: all valid and held → `req_ready` = 000011, 001100, 110000, 000011 on successive cycles. `wb_out_data` `rd_phy` pairs lag one cycle: (0,1), (2,3), (4,5), (0,1). `rr_ptr` = 2, 4, 0.
- Sparse: `rr_ptr`=0, only req 4 valid → `req_ready`=010000. Next cycle: ch0 `rd_phy`=4 `rd_value`='h1526331B, `wb_out_valid`=01, `rr_ptr`=5.
- Wrap: `rr_ptr`=5, reqs 0, 1, 5 valid → `req_ready`=100001. Next cycle: ch0 `rd_phy`=5, ch1 `rd_phy`=0, `rr_ptr`=1.
- Stall: output holds (0,1) and `wb_stall`=1 for 2 cycles with all valid → `req_ready`=0, outputs and `rr_ptr`=2 unchanged. After release, `req_ready`=001100.
- Flush+stall: with outputs valid, `flush`=1 and `wb_stall`=1 together → `req_ready`=0. Next cycle: `wb_out_valid`=00, `rr_ptr`=0.
